clkgen_ctrl: RTL and testbench

Runtime-programmable, glitch-free square-wave generator and sequencer for the board test clock path. Software or a test FSM loads a half-period divisor and a run or stop command through a valid/ready handshake. The block starts, retunes and stops `clkout` only at half-period boundaries, so no runt pulses are produced. It replaces fixed-frequency division where the Test harness needs frequency changes and, optionally, counted bursts.

---
 rtl/clkgen_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_clkgen_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_ctrl.sv
// clkgen_ctrl: runtime-programmable, glitch-free square-wave generator.
// A half-period divisor and a run/stop command arrive over a valid/ready
// handshake; clkout only starts, retunes or stops on half-period boundaries.
// Optional feature macro CLKGEN_BURST_EN adds the cfg_burst port and a
// rise counter so a run can stop itself after N rising edges.
module clkgen_ctrl #(
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 4999
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_run,
`ifdef CLKGEN_BURST_EN
    input  logic [15:0]      cfg_burst,
`endif
    output logic             clkout,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;

    // Shadow holds one pending request while running; applied at a boundary.
    logic             sh_vld_q, sh_vld_d;
    logic [CNT_W-1:0] sh_half_q, sh_half_d;
    logic             sh_run_q, sh_run_d;

    logic             clkout_q, clkout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             done_q, done_d;

    logic             boundary;
    logic             accept;
    logic             stop_now;

`ifdef CLKGEN_BURST_EN
    logic [15:0]      brem_q, brem_d;
    logic [15:0]      sh_burst_q, sh_burst_d;
    logic [15:0]      burst_eff;
`endif

    // Handshake: free in STOP, in RUN only while the shadow is empty.
    assign cfg_ready = (state_q == ST_STOP) || ((state_q == ST_RUN) && !sh_vld_q);
    assign accept    = cfg_valid && cfg_ready;

    // A half-phase ends when the counter reaches the divisor (unsigned, so a
    // divisor lowered below the running count still ends the phase at once).
    assign boundary  = (state_q != ST_STOP) && (cnt_q >= half_q);

    // Next-state, counter, shadow and output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        sh_vld_d   = sh_vld_q;
        sh_half_d  = sh_half_q;
        sh_run_d   = sh_run_q;
        clkout_d   = clkout_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        done_d     = 1'b0;
        stop_now   = 1'b0;
`ifdef CLKGEN_BURST_EN
        brem_d     = brem_q;
        sh_burst_d = sh_burst_q;
        burst_eff  = brem_q;
`endif

        if (state_q != ST_STOP) begin
            cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_STOP: begin
                // Divisor is written directly; a run command starts a fresh phase.
                if (accept) begin
                    half_d = cfg_half;
                    if (cfg_run) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
`ifdef CLKGEN_BURST_EN
                        brem_d  = cfg_burst;
`endif
                    end
                end
            end

            ST_RUN: begin
                if (boundary) begin
                    // Pending request takes effect for the phase that starts now.
                    if (sh_vld_q) begin
                        half_d   = sh_half_q;
                        sh_vld_d = 1'b0;
                        stop_now = !sh_run_q;
`ifdef CLKGEN_BURST_EN
                        burst_eff = sh_burst_q;
`endif
                    end
                    if (!stop_now) begin
                        clkout_d = !clkout_q;
                        rise_d   = !clkout_q;
                        fall_d   = clkout_q;
`ifdef CLKGEN_BURST_EN
                        // Count this rise against the burst; the last one drains.
                        brem_d = burst_eff;
                        if (!clkout_q && (burst_eff != 16'd0)) begin
                            brem_d = burst_eff - 16'd1;
                            if (burst_eff == 16'd1) begin
                                state_d = ST_DRAIN;
                            end
                        end
`endif
                    end
                end
                // Requests landing on a boundary edge wait for the next boundary.
                if (accept) begin
                    sh_vld_d  = 1'b1;
                    sh_half_d = cfg_half;
                    sh_run_d  = cfg_run;
`ifdef CLKGEN_BURST_EN
                    sh_burst_d = cfg_burst;
`endif
                end
            end

            ST_DRAIN: begin
                stop_now = boundary;
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase

        // Stop at a boundary: a high clkout falls normally, a low one stays low.
        if (stop_now) begin
            state_d  = ST_STOP;
            clkout_d = 1'b0;
            fall_d   = clkout_q;
            done_d   = 1'b1;
            sh_vld_d = 1'b0;
            cnt_d    = '0;
`ifdef CLKGEN_BURST_EN
            brem_d   = '0;
`endif
        end
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            cnt_q      <= '0;
            half_q     <= CNT_W'(DEFAULT_HALF);
            sh_vld_q   <= 1'b0;
            sh_half_q  <= '0;
            sh_run_q   <= 1'b0;
            clkout_q   <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CLKGEN_BURST_EN
            brem_q     <= '0;
            sh_burst_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            sh_vld_q   <= sh_vld_d;
            sh_half_q  <= sh_half_d;
            sh_run_q   <= sh_run_d;
            clkout_q   <= clkout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            done_q     <= done_d;
`ifdef CLKGEN_BURST_EN
            brem_q     <= brem_d;
            sh_burst_q <= sh_burst_d;
`endif
        end
    end

    assign clkout    = clkout_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_STOP);

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed testbench for clkgen_ctrl. Burst checks are built when
// CLKGEN_BURST_EN is defined.
module tb_clkgen_ctrl;

    logic        clkin;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_half;
    logic        cfg_run;
`ifdef CLKGEN_BURST_EN
    logic [15:0] cfg_burst;
`endif
    logic        clkout;
    logic        rise_tick;
    logic        fall_tick;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    clkgen_ctrl #(.CNT_W(32), .DEFAULT_HALF(4999)) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_run   (cfg_run),
`ifdef CLKGEN_BURST_EN
        .cfg_burst (cfg_burst),
`endif
        .clkout    (clkout),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .busy      (busy),
        .done      (done)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    // Present one request, accepted on the next edge.
    task automatic send(input logic [31:0] h, input logic run);
        cfg_valid = 1'b1;
        cfg_half  = h;
        cfg_run   = run;
        step();
        cfg_valid = 1'b0;
    endtask

    // Edges until an event (0 rise, 1 fall, 2 done); -1 when the bound expires.
    task automatic wait_ev(input int mode, input int max, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < max) begin
            step();
            n++;
            case (mode)
                0:       hit = rise_tick;
                1:       hit = fall_tick;
                default: hit = done;
            endcase
        end
        if (!hit) n = -1;
    endtask

    initial begin
        int n;
        int rises;
        int bad;
        bit drain;

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        cfg_run   = 1'b0;
`ifdef CLKGEN_BURST_EN
        cfg_burst = '0;
`endif
        #12;
        chk("rst_clkout", {31'd0, clkout}, 0);
        chk("rst_ticks", {30'd0, rise_tick, fall_tick}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ready", {31'd0, cfg_ready}, 1);
        #10 rst_n = 1'b1;

        // Start half=4: first rise 5 edges after acceptance, 5 high / 5 low.
        send(32'd4, 1'b1);
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_clkout", {31'd0, clkout}, 0);
        wait_ev(0, 20, n);
        chk("start_first_rise", n, 5);
        chk("start_clkout_hi", {31'd0, clkout}, 1);
        step();
        chk("rise_single", {31'd0, rise_tick}, 0);
        wait_ev(1, 20, n);
        chk("high_len", n + 1, 5);
        step();
        chk("fall_single", {31'd0, fall_tick}, 0);
        wait_ev(0, 20, n);
        chk("low_len", n + 1, 5);

        // Retune to half=1 two cycles after a rise.
        step();
        send(32'd1, 1'b1);
        chk("retune_ready_low", {31'd0, cfg_ready}, 0);
        wait_ev(1, 20, n);
        chk("retune_high_rest", n, 3);
        chk("retune_ready_back", {31'd0, cfg_ready}, 1);
        wait_ev(0, 20, n);
        chk("retune_low", n, 2);
        wait_ev(1, 20, n);
        chk("retune_high", n, 2);

        // Request on a boundary edge is applied one boundary later.
        wait_ev(0, 20, n);
        chk("bnd_rise", n, 2);
        step();
        cfg_valid = 1'b1;
        cfg_half  = 32'd3;
        cfg_run   = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("bnd_fall_same_edge", {31'd0, fall_tick}, 1);
        chk("bnd_ready_low", {31'd0, cfg_ready}, 0);
        wait_ev(0, 20, n);
        chk("bnd_old_half", n, 2);
        wait_ev(1, 20, n);
        chk("bnd_new_half", n, 4);
        chk("bnd_ready_back", {31'd0, cfg_ready}, 1);

        // Stop while high: fall on time, done on the same edge.
        wait_ev(0, 20, n);
        chk("stophi_rise", n, 4);
        step();
        send(32'd3, 1'b0);
        wait_ev(1, 20, n);
        chk("stophi_fall", n, 2);
        chk("stophi_done", {31'd0, done}, 1);
        chk("stophi_clkout", {31'd0, clkout}, 0);
        chk("stophi_busy", {31'd0, busy}, 0);
        step();
        chk("stophi_done_pulse", {31'd0, done}, 0);
        chk("stophi_ready", {31'd0, cfg_ready}, 1);

        // Stop while low: rise suppressed, done at the boundary.
        send(32'd2, 1'b1);
        wait_ev(0, 20, n);
        chk("stoplo_rise", n, 3);
        wait_ev(1, 20, n);
        chk("stoplo_fall", n, 3);
        step();
        send(32'd2, 1'b0);
        wait_ev(2, 20, n);
        chk("stoplo_done", n, 1);
        chk("stoplo_no_tick", {30'd0, rise_tick, fall_tick}, 0);
        chk("stoplo_clkout", {31'd0, clkout}, 0);
        step();
        step();
        chk("stoplo_stays_low", {31'd0, clkout}, 0);
        chk("stoplo_busy", {31'd0, busy}, 0);

        // half=0: clkout toggles every cycle.
        send(32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("half0_toggle", {31'd0, clkout}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        send(32'd0, 1'b0);
        wait_ev(2, 10, n);
        chk("half0_stop", n, 1);
        chk("half0_clkout", {31'd0, clkout}, 0);

`ifdef CLKGEN_BURST_EN
        // Burst of 3 at half=2: 3 rises, done with the 3rd fall at edge k+18.
        cfg_burst = 16'd3;
        send(32'd2, 1'b1);
        cfg_burst = 16'd0;
        n     = 0;
        rises = 0;
        bad   = 0;
        drain = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            if (rise_tick) rises++;
            if (rise_tick && rises == 3) begin
                drain     = 1'b1;
                cfg_valid = 1'b1;
                cfg_half  = 32'd2;
                cfg_run   = 1'b0;
            end
            if (drain && !done && cfg_ready !== 1'b0) bad++;
        end
        chk("burst_done_edge", n, 18);
        chk("burst_rises", rises, 3);
        chk("burst_drain_ready", bad, 0);
        chk("burst_stop_ready", {31'd0, cfg_ready}, 1);
        step();
        cfg_valid = 1'b0;
        chk("burst_busy", {31'd0, busy}, 0);

        // Burst 0 is continuous.
        send(32'd2, 1'b1);
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            wait_ev(0, 20, n);
            if (n != ((i == 0) ? 3 : 6)) bad++;
        end
        chk("burst0_rises", bad, 0);
        chk("burst0_busy", {31'd0, busy}, 1);
        send(32'd2, 1'b0);
        wait_ev(2, 20, n);
        chk("burst0_stopped", {31'd0, busy}, 0);
`endif

        // Reset mid-run clears outputs immediately, then default-rate start.
        send(32'd4, 1'b1);
        wait_ev(0, 20, n);
        chk("rst2_rise", n, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_clkout", {31'd0, clkout}, 0);
        chk("rst2_tick", {31'd0, rise_tick}, 0);
        chk("rst2_busy", {31'd0, busy}, 0);
        chk("rst2_ready", {31'd0, cfg_ready}, 1);
        #2 rst_n = 1'b1;
        send(32'd4999, 1'b1);
        wait_ev(0, 6000, n);
        chk("slow_first_rise", n, 5000);
        wait_ev(1, 6000, n);
        chk("slow_high", n, 5000);
        wait_ev(0, 6000, n);
        chk("slow_low", n, 5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
